// File: rtl/axi4_mem_loader_pkg.sv
// Shared types and AXI constants for the memory loader and its burst splitter.
package axi4_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_split.sv
// Burst length and follow-on address for an INCR burst starting at addr:
// limited by remaining beats, BURST_LEN and the next 4 KB boundary.
module axi4_burst_split #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       remaining,
  output logic [8:0]        len,
  output logic [ADDR_W-1:0] next_addr
);
  import axi4_mem_loader_pkg::*;

  localparam int SZ = $clog2(DATA_W/8);

  logic [12:0] room_bytes;
  logic [15:0] room_beats;
  logic [15:0] cap;

  always_comb begin
    // addr is beat-aligned, so the byte distance divides exactly
    room_bytes = BOUNDARY_4K - {1'b0, addr[11:0]};
    room_beats = 16'(room_bytes >> SZ);
    cap        = min16(min16(remaining, 16'(BURST_LEN)), room_beats);
    len        = cap[8:0];
    next_addr  = addr + (ADDR_W'(cap) << SZ);
  end

  logic unused_hi;
  assign unused_hi = ^cap[15:9];

endmodule

// File: rtl/axi4_mem_loader.sv
// Stream-to-memory AXI4 writer with one burst in flight.
// AXI4_MEM_LOADER_READBACK_EN adds a checksum re-read of the written region.
module axi4_mem_loader #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 0,
  parameter int BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           num_beats,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);
  import axi4_mem_loader_pkg::*;

  localparam int SZ = $clog2(DATA_W/8);

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_q, base_q, nxt_addr;
  logic [15:0]       rem_q, total_q, rem_after;
  logic [8:0]        beat_q, len;
  logic [1:0]        err_q;
  logic              last_beat;
  logic [7:0]        len_field;

  axi4_burst_split #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) u_split (
    .addr(addr_q), .remaining(rem_q), .len(len), .next_addr(nxt_addr)
  );

  assign rem_after = rem_q - 16'(len);
  assign last_beat = (beat_q == len - 9'd1);
  // len is 0 only when nothing is left; keep the field at 0 then
  assign len_field = (len == 9'd0) ? 8'd0 : 8'(len - 9'd1);

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = len_field;
  assign awsize  = 3'(SZ);
  assign awburst = BURST_INCR;
  assign wdata   = s_data;
  assign wstrb   = '1;
  assign err     = err_q;

`ifdef AXI4_MEM_LOADER_READBACK_EN
  logic [63:0] wsum_q, rsum_q, rsum_nxt;
  assign rsum_nxt = rsum_q + 64'(rdata);
  assign arid     = ID_W'(AXI_ID);
  assign araddr   = addr_q;
  assign arlen    = len_field;
  assign arsize   = 3'(SZ);
  assign arburst  = BURST_INCR;
`else
  assign arvalid  = 1'b0;
  assign rready   = 1'b0;
  assign arid     = '0;
  assign araddr   = '0;
  assign arlen    = '0;
  assign arsize   = '0;
  assign arburst  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    busy    = 1'b1;
    done    = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    s_ready = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
`ifdef AXI4_MEM_LOADER_READBACK_EN
    arvalid = 1'b0;
    rready  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) nxt = (num_beats == '0) ? ST_DONE : ST_AW;
      end
      ST_AW: begin
        awvalid = 1'b1;
        if (awready) nxt = ST_W;
      end
      ST_W: begin
        wvalid  = s_valid;
        s_ready = wready;
        wlast   = last_beat;
        if (s_valid && wready && last_beat) nxt = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) begin
          if (rem_after != '0) nxt = ST_AW;
`ifdef AXI4_MEM_LOADER_READBACK_EN
          else                 nxt = ST_AR;
`else
          else                 nxt = ST_DONE;
`endif
        end
      end
`ifdef AXI4_MEM_LOADER_READBACK_EN
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) nxt = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid && last_beat) nxt = (rem_after != '0) ? ST_AR : ST_DONE;
      end
`endif
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default: begin
        busy = 1'b0;
        nxt  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      base_q  <= '0;
      rem_q   <= '0;
      total_q <= '0;
      beat_q  <= '0;
      err_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          base_q  <= {base_addr[ADDR_W-1:SZ], {SZ{1'b0}}};
          addr_q  <= {base_addr[ADDR_W-1:SZ], {SZ{1'b0}}};
          rem_q   <= num_beats;
          total_q <= num_beats;
          beat_q  <= '0;
          err_q   <= '0;
        end
        ST_AW: beat_q <= '0;
        ST_W:  if (s_valid && wready) beat_q <= beat_q + 9'd1;
        ST_B:  if (bvalid) begin
          if (bresp != RESP_OKAY) err_q[0] <= 1'b1;
          addr_q <= nxt_addr;
          rem_q  <= rem_after;
`ifdef AXI4_MEM_LOADER_READBACK_EN
          // rewind so the readback walks the identical burst sequence
          if (rem_after == '0) begin
            addr_q <= base_q;
            rem_q  <= total_q;
          end
`endif
        end
`ifdef AXI4_MEM_LOADER_READBACK_EN
        ST_AR: beat_q <= '0;
        ST_R:  if (rvalid) begin
          beat_q <= beat_q + 9'd1;
          if (rresp != RESP_OKAY) err_q[0] <= 1'b1;
          if (last_beat) begin
            addr_q <= nxt_addr;
            rem_q  <= rem_after;
            if (rem_after == '0 && rsum_nxt != wsum_q) err_q[1] <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef AXI4_MEM_LOADER_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsum_q <= '0;
      rsum_q <= '0;
    end else if (state == ST_IDLE && start) begin
      wsum_q <= '0;
      rsum_q <= '0;
    end else begin
      if (state == ST_W && s_valid && wready) wsum_q <= wsum_q + 64'(s_data);
      if (state == ST_R && rvalid)            rsum_q <= rsum_nxt;
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{bid, rid, rlast, base_addr[SZ-1:0]};
`else
  logic unused_sigs;
  assign unused_sigs = ^{bid, rid, rlast, base_addr[SZ-1:0], arready, rvalid, rdata, rresp};
`endif

endmodule

// File: tb/tb_axi4_mem_loader.sv
// Scoreboard bench: randomized AXI slave with stalls, reference burst planner,
// monitor comparing AW/AR/W/done against queued expectations.
module tb_axi4_mem_loader;
  localparam int ADDR_W = 32, DATA_W = 64, ID_W = 4, BL = 16;

  logic clk = 1'b0;
  logic rst_n, start, s_valid, s_ready, busy, done;
  logic [ADDR_W-1:0] base_addr, awaddr, araddr;
  logic [15:0] num_beats;
  logic [DATA_W-1:0] s_data, wdata, rdata;
  logic [1:0] err, bresp, rresp, awburst, arburst;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize;

  always #5 clk = ~clk;

  axi4_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .busy(busy), .done(done), .err(err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct { logic [31:0] a; int n; } seg_t;
  typedef struct { logic [63:0] d; logic l; } wexp_t;

  seg_t  segs[$], exp_aw[$], exp_ar[$], aw_q[$], ar_q[$];
  wexp_t exp_w[$];
  logic [1:0]  exp_err[$];
  logic [63:0] src[$];
  logic [63:0] mem [logic [31:0]];

  int n_chk = 0, n_err = 0, done_cnt = 0, done_cyc = 0, spur = 0, cyc = 0;
  int rdy_pct = 80, sv_pct = 80, bv_pct = 60;
  int slverr_idx = -1, b_idx = 0, pend_b = 0, wbeat = 0, rbeat = 0;
  bit corrupt_en = 0;
  logic [31:0] corrupt_addr = '0;
  bit hs_aw, hs_w, hs_s, hs_b, hs_ar, hs_r;
  logic [31:0] sl_a;
  seg_t  m_seg;
  wexp_t m_w;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Reference segmentation: min(remaining, BL, beats left in the 4 KB page)
  function automatic void plan(input logic [31:0] base, input int n);
    logic [31:0] a;
    int r, room, l;
    a = {base[31:3], 3'b000};
    r = n;
    segs.delete();
    while (r > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 8;
      l = r;
      if (l > BL) l = BL;
      if (l > room) l = room;
      segs.push_back('{a, l});
      a = a + 32'(l * 8);
      r -= l;
    end
  endfunction

  // AXI slave + stream source
  initial begin
    {hs_aw, hs_w, hs_s, hs_b, hs_ar, hs_r} = '0;
    forever begin
      @(negedge clk);
      if (hs_s) s_valid = 1'b0;
      if (hs_b) bvalid = 1'b0;
      if (hs_r) rvalid = 1'b0;
      awready = ($urandom_range(0, 99) < rdy_pct);
      wready  = ($urandom_range(0, 99) < rdy_pct);
      arready = ($urandom_range(0, 99) < rdy_pct);
      if (!s_valid && src.size() > 0 && $urandom_range(0, 99) < sv_pct) begin
        s_valid = 1'b1;
        s_data  = src[0];
      end
      if (!bvalid && pend_b > 0 && $urandom_range(0, 99) < bv_pct) begin
        bvalid = 1'b1;
        bresp  = (b_idx == slverr_idx) ? 2'b10 : 2'b00;
      end
      if (!rvalid && ar_q.size() > 0 && $urandom_range(0, 99) < bv_pct) begin
        sl_a  = ar_q[0].a + 32'(rbeat * 8);
        rdata = mem.exists(sl_a) ? mem[sl_a] : '0;
        if (corrupt_en && sl_a == corrupt_addr) rdata[0] = ~rdata[0];
        rlast  = (rbeat == ar_q[0].n - 1);
        rvalid = 1'b1;
      end
      #1;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_s  = s_valid && s_ready;
      hs_b  = bvalid && bready;
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (hs_aw) aw_q.push_back('{awaddr, int'(awlen) + 1});
      if (hs_w && aw_q.size() > 0) begin
        sl_a = aw_q[0].a + 32'(wbeat * 8);
        mem[sl_a] = wdata;
        wbeat++;
        if (wbeat >= aw_q[0].n) begin
          void'(aw_q.pop_front());
          wbeat = 0;
          pend_b++;
        end
      end
      if (hs_s && src.size() > 0) void'(src.pop_front());
      if (hs_b) begin pend_b--; b_idx++; end
      if (hs_ar) ar_q.push_back('{araddr, int'(arlen) + 1});
      if (hs_r && ar_q.size() > 0) begin
        rbeat++;
        if (rbeat >= ar_q[0].n) begin
          void'(ar_q.pop_front());
          rbeat = 0;
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst_n) begin
        if (awvalid && exp_aw.size() == 0) spur++;
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) fail("aw_extra");
          else begin
            m_seg = exp_aw.pop_front();
            check("awaddr", awaddr, m_seg.a);
            check("awlen", awlen, 64'(m_seg.n - 1));
            check("aw_attr", {awid, awsize, awburst}, {4'd0, 3'd3, 2'b01});
          end
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) fail("w_extra");
          else begin
            m_w = exp_w.pop_front();
            check("wdata", wdata, m_w.d);
            check("wlast", wlast, m_w.l);
            check("wstrb", wstrb, 8'hFF);
          end
        end
`ifdef AXI4_MEM_LOADER_READBACK_EN
        if (arvalid && exp_ar.size() == 0) spur++;
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) fail("ar_extra");
          else begin
            m_seg = exp_ar.pop_front();
            check("araddr", araddr, m_seg.a);
            check("arlen", arlen, 64'(m_seg.n - 1));
          end
        end
`else
        if (arvalid || rready) spur++;
`endif
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_err.size() == 0) fail("done_extra");
          else check("err", err, exp_err.pop_front());
        end
      end
    end
  end

  task automatic run(input logic [31:0] base, input int n, input bit seq, input int serr,
                     input bit corrupt, input bit poke);
    logic [63:0] words[$];
    logic [31:0] al;
    logic [1:0]  e;
    int d0, t, t0, k, bad;
    al = {base[31:3], 3'b000};
    plan(base, n);
    foreach (segs[i]) begin
      exp_aw.push_back(segs[i]);
`ifdef AXI4_MEM_LOADER_READBACK_EN
      exp_ar.push_back(segs[i]);
`endif
    end
    for (int i = 0; i < n; i++) words.push_back(seq ? 64'(i + 1) : {$urandom, $urandom});
    k = 0;
    foreach (segs[s]) begin
      for (int j = 0; j < segs[s].n; j++) begin
        exp_w.push_back('{words[k], j == segs[s].n - 1});
        k++;
      end
    end
    e[0] = (serr >= 0 && serr < segs.size());
`ifdef AXI4_MEM_LOADER_READBACK_EN
    e[1] = corrupt && (n > 0);
`else
    e[1] = 1'b0;
`endif
    exp_err.push_back(e);
    mem.delete();
    slverr_idx   = serr;
    b_idx        = 0;
    corrupt_en   = corrupt;
    corrupt_addr = al + 32'((n / 2) * 8);
    spur         = 0;
    foreach (words[i]) src.push_back(words[i]);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_beats = 16'(n); t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    #3 check("busy_after_start", busy, 64'(n != 0));
    if (n == 0) check("zero_done_latency", done_cyc - t0, 2);
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1'b1; base_addr = 32'h1000_0000; num_beats = 16'd3;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      fail("done_timeout");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
    repeat (2) @(negedge clk);
    check("queues_drained", exp_aw.size() + exp_ar.size() + exp_w.size() + exp_err.size(), 0);
    check("no_spurious_addr", spur, 0);
    if (n > 0) begin
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (!mem.exists(al + 32'(i * 8)) || mem[al + 32'(i * 8)] !== words[i]) bad++;
      end
      check("mem_contents", bad, 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_beats = '0;
    s_valid = 1'b0; s_data = '0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0; arready = 1'b0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_handshakes", {awvalid, wvalid, s_ready, bready, arvalid, rready}, 0);
    check("rst_status", {busy, done, err}, 0);
    check("rst_addr_len", {awaddr, awlen, araddr, arlen}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(32'h8000_0000, 4, 1, -1, 0, 0);
    run(32'h8000_0000, 0, 0, -1, 0, 0);
    run(32'h8000_0000, 40, 0, -1, 0, 0);
    run(32'h8000_0FF0, 5, 0, -1, 0, 0);
    run(32'h8000_0000, 48, 0, 1, 0, 0);
    run(32'h8000_0000, 16, 0, -1, 0, 0);
    rdy_pct = 40; sv_pct = 50; bv_pct = 30;
    run(32'h8000_2F00, 100, 0, -1, 0, 1);
    run(32'hFFFF_FFE0, 10, 0, -1, 0, 0);
    for (int i = 0; i < 3; i++)
      run({8'h80, 21'($urandom), 3'b000}, $urandom_range(1, 60), 0, -1, 0, 0);
`ifdef AXI4_MEM_LOADER_READBACK_EN
    run(32'h8000_0FC0, 20, 0, -1, 1, 0);
    run(32'h8000_0FC0, 20, 0, -1, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
